fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 130 +++++++++++++
 tb/tb_fetch_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches over req/gnt/rvalid, computes next PC on retire.
// Define FETCH_MISALIGN_TRAP_EN to redirect misaligned targets to the trap vector and pulse trap_o.
module fetch_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        jal_i,
  input  logic        jalr_i,
  input  logic        branch_i,
  input  logic        branch_taken_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] rs1_i,
  input  logic        retire_i,
  output logic [31:0] instr_o,
  output logic [6:0]  op_code_o,
  output logic [2:0]  funct3_o,
  output logic        fnc7_h20_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        instr_valid_o,
  output logic        trap_o
);

  // state | meaning
  // BOOT  | one idle cycle after reset release
  // REQ   | request held on imem until granted
  // WAIT  | granted, waiting for read data
  // VALID | instruction presented, waiting for retire
  localparam logic [1:0]  S_BOOT   = 2'd0;
  localparam logic [1:0]  S_REQ    = 2'd1;
  localparam logic [1:0]  S_WAIT   = 2'd2;
  localparam logic [1:0]  S_VALID  = 2'd3;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] target;
  logic [31:0] pc_next;
  logic        retire_fire;

  assign retire_fire = (state_q == S_VALID) && retire_i;

  always_comb begin
    if (jalr_i)                        target = (rs1_i + imm_i) & ~32'h1;
    else if (jal_i)                    target = pc_q + imm_i;
    else if (branch_i && branch_taken_i) target = pc_q + imm_i;
    else                               target = pc_q + 32'd4;
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
  logic misaligned;
  logic trap_q;

  assign misaligned = (target[1:0] != 2'b00);
  assign pc_next    = misaligned ? TRAP_VEC : target;
  assign trap_o     = trap_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) trap_q <= 1'b0;
    else       trap_q <= retire_fire && misaligned;
  end
`else
  assign pc_next = target & ~32'h3;
  assign trap_o  = 1'b0;
`endif

  // Response is captured into a register first; it is only accepted while WAIT so
  // stray responses landing in BOOT/REQ (e.g. after a reset abort) are dropped.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    rvalid_d = (state_q == S_WAIT) && imem_rvalid_i;
    rdata_d  = rdata_q;
    if ((state_q == S_WAIT) && imem_rvalid_i) rdata_d = imem_rdata_i;
    case (state_q)
      S_BOOT:  state_d = S_REQ;
      S_REQ:   if (imem_gnt_i) state_d = S_WAIT;
      S_WAIT: begin
        if (rvalid_q) begin
          instr_d = rdata_q;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (retire_i) begin
          pc_d    = pc_next;
          state_d = S_REQ;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_BOOT;
      pc_q     <= RESET_PC;
      instr_q  <= NOP;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign imem_req_o    = (state_q == S_REQ);
  assign imem_addr_o   = pc_q;
  assign instr_o       = instr_q;
  assign op_code_o     = instr_q[6:0];
  assign funct3_o      = instr_q[14:12];
  assign fnc7_h20_o    = instr_q[30];
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_q + 32'd4;
  assign instr_valid_o = (state_q == S_VALID);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomized bench for fetch_unit with a PC-sequence reference model.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        jal, jalr, branch, taken, retire;
  logic [31:0] imm, rs1;
  logic [31:0] instr, pc, pc_plus4;
  logic [6:0]  op_code;
  logic [2:0]  funct3;
  logic        fnc7_h20, instr_valid, trap;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc;
  logic        exp_trap;

  fetch_unit dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(imem_gnt),
    .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
    .jal_i(jal), .jalr_i(jalr), .branch_i(branch), .branch_taken_i(taken),
    .imm_i(imm), .rs1_i(rs1), .retire_i(retire),
    .instr_o(instr), .op_code_o(op_code), .funct3_o(funct3), .fnc7_h20_o(fnc7_h20),
    .pc_o(pc), .pc_plus4_o(pc_plus4), .instr_valid_o(instr_valid), .trap_o(trap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: the architectural next-PC rule evaluated on the model's own PC.
  function automatic void model_retire(input logic j, input logic jr, input logic b, input logic t,
                                       input logic [31:0] im, input logic [31:0] r1);
    longint unsigned sum;
    logic [31:0] tgt;
    if (jr)          sum = (longint'(r1) + longint'(im)) % 64'h1_0000_0000;
    else if (j)      sum = (longint'(exp_pc) + longint'(im)) % 64'h1_0000_0000;
    else if (b && t) sum = (longint'(exp_pc) + longint'(im)) % 64'h1_0000_0000;
    else             sum = (longint'(exp_pc) + 4) % 64'h1_0000_0000;
    tgt = sum[31:0];
    if (jr) tgt[0] = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    exp_trap = (tgt % 4) != 0;
    exp_pc   = exp_trap ? 32'h100 : tgt;
`else
    exp_trap = 1'b0;
    exp_pc   = tgt - (tgt % 4);
`endif
  endfunction

  // Fetch one instruction from the current REQ state, then retire it with the given controls.
  task automatic do_instr(input int gd, input int rd, input logic [31:0] word,
                          input logic j, input logic jr, input logic b, input logic t,
                          input logic [31:0] im, input logic [31:0] r1, input int hold);
    int n;
    n = 0;
    check("req_high", {31'b0, imem_req}, 32'd1);
    check("req_addr", imem_addr, exp_pc);
    for (int i = 0; i < gd; i++) begin
      @(negedge clk); n++;
      check("addr_stable", imem_addr, exp_pc);
    end
    imem_gnt = 1'b1;
    @(negedge clk); n++;
    imem_gnt = 1'b0;
    for (int i = 0; i < rd; i++) begin
      @(negedge clk); n++;
    end
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    @(negedge clk); n++;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    while (!instr_valid && n < 40) begin
      @(negedge clk); n++;
    end
    check("valid_latency", n, 3 + gd + rd);
    check("instr", instr, word);
    check("op_code", {25'b0, op_code}, {25'b0, word[6:0]});
    check("funct3", {29'b0, funct3}, {29'b0, word[14:12]});
    check("fnc7_h20", {31'b0, fnc7_h20}, {31'b0, word[30]});
    check("pc", pc, exp_pc);
    check("pc_plus4", pc_plus4, exp_pc + 32'd4);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("valid_hold", {31'b0, instr_valid}, 32'd1);
    end
    jal = j; jalr = jr; branch = b; taken = t; imm = im; rs1 = r1; retire = 1'b1;
    @(negedge clk);
    retire = 1'b0; jal = 1'b0; jalr = 1'b0; branch = 1'b0; taken = 1'b0;
    imm = $urandom; rs1 = $urandom;
    model_retire(j, jr, b, t, im, r1);
    check("valid_drop", {31'b0, instr_valid}, 32'd0);
    check("trap", {31'b0, trap}, {31'b0, exp_trap});
    check("instr_held", instr, word);
  endtask

  initial begin
    logic [31:0] w, im, r1;
    logic j, jr, b, t;
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    jal = 1'b0; jalr = 1'b0; branch = 1'b0; taken = 1'b0; retire = 1'b0;
    imm = 32'h0; rs1 = 32'h0;
    exp_pc = 32'h0; exp_trap = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_instr", instr, 32'h13);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_trap", {31'b0, trap}, 32'd0);
    rst = 1'b0;
    check("boot_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk);

    // Boot fetch with zero wait, then sequential fetches with gnt/rvalid stalls.
    do_instr(0, 0, 32'h0050_0093, 0, 0, 0, 0, 0, 0, 0);
    check("boot_opcode", {25'b0, op_code}, 32'h13);
    check("boot_funct3", {29'b0, funct3}, 32'h0);
    check("seq_addr4", imem_addr, 32'h4);
    do_instr(2, 1, 32'h0010_8113, 0, 0, 0, 0, 0, 0, 0);
    check("seq_addr8", imem_addr, 32'h8);
    do_instr(2, 1, 32'h4020_81b3, 1, 0, 0, 0, 32'h18, 0, 0);
    check("jal_to20", imem_addr, 32'h20);
    do_instr(0, 0, 32'h0400_006f, 1, 0, 0, 0, 32'h40, 0, 1);
    check("jal_addr", imem_addr, 32'h60);
    do_instr(1, 0, 32'h0040_8067, 0, 1, 0, 0, 32'h4, 32'h101, 0);
    check("jalr_addr", imem_addr, 32'h104);
    do_instr(0, 2, 32'hf0df_f06f, 1, 0, 0, 0, 32'hFFFF_FF0C, 0, 0);
    check("jal_to10", imem_addr, 32'h10);
    do_instr(0, 0, 32'hfe20_8ce3, 0, 0, 1, 1, 32'hFFFF_FFF8, 0, 0);
    check("br_taken", imem_addr, 32'h08);
    do_instr(0, 0, 32'h0080_006f, 1, 0, 0, 0, 32'h8, 0, 0);
    do_instr(0, 0, 32'hfe20_8ce3, 0, 0, 1, 0, 32'hFFFF_FFF8, 0, 0);
    check("br_not_taken", imem_addr, 32'h14);
    do_instr(0, 0, 32'hfe9f_f06f, 1, 0, 0, 0, 32'hFFFF_FFE8, 0, 0);
    check("jal_top", imem_addr, 32'hFFFF_FFFC);
    do_instr(1, 1, 32'h0000_0013, 0, 0, 0, 0, 0, 0, 0);
    check("wrap_addr", imem_addr, 32'h0);
    do_instr(0, 0, 32'h0060_006f, 1, 0, 0, 0, 32'h6, 0, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("misalign_addr", imem_addr, 32'h100);
    check("misalign_trap", {31'b0, trap}, 32'd1);
`else
    check("misalign_addr", imem_addr, 32'h4);
    check("misalign_trap", {31'b0, trap}, 32'd0);
`endif

    // Randomized control flow against the model.
    for (int k = 0; k < 16; k++) begin
      w  = $urandom;
      j  = ($urandom_range(0, 3) == 0);
      jr = ($urandom_range(0, 4) == 0);
      b  = $urandom_range(0, 1);
      t  = $urandom_range(0, 1);
      im = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      r1 = $urandom;
      do_instr($urandom_range(0, 3), $urandom_range(0, 3), w, j, jr, b, t, im, r1,
               $urandom_range(0, 2));
    end

    // Reset while WAIT; stale response during BOOT must be discarded.
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    check("in_wait_req", {31'b0, imem_req}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst2_instr", instr, 32'h13);
    check("rst2_pc", pc, 32'h0);
    rst = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    exp_pc = 32'h0;
    check("stale_instr", instr, 32'h13);
    check("stale_valid", {31'b0, instr_valid}, 32'd0);
    do_instr(0, 0, 32'h0020_0113, 0, 0, 0, 0, 0, 0, 0);
    check("after_rst_addr", imem_addr, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
